// File: rtl/aes_stream_ctrl_if.sv
// Request/response handshake bundle between a client and aes_stream_ctrl.
// The client uses the master modport and the controller uses the slave modport.
interface aes_stream_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_err;

  modport master (output in_valid, in_key, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_err);
  modport slave  (input  in_valid, in_key, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_err);
endinterface

// File: rtl/aes_stream_ctrl.sv
// Sequencer for a byte-serial AES-128 core: streams key/plaintext bytes in,
// collects 16 ciphertext bytes out, and aborts with out_err on a stalled core.
module aes_stream_ctrl #(
  parameter int TIMEOUT = 1024  // legal range 2..65535
) (
  input  logic                    clk,
  input  logic                    rst,
  aes_stream_ctrl_if.slave        bus,
  output logic                    busy,
  output logic                    core_rst,
  output logic [7:0]              core_keyin,
  output logic [7:0]              core_datain,
  input  logic [7:0]              core_dout,
  input  logic                    core_valid
);
  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [3:0]    byte_cnt_r;
  logic [TW-1:0] to_cnt_r;
  logic [127:0]  key_sr_r, data_sr_r, res_r;
  logic [7:0]    keyin_r, datain_r;
  logic          err_r, in_ready_r, out_valid_r, busy_r, core_rst_r;

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: if (bus.in_valid) state_s = LOAD; else state_s = IDLE;
      LOAD: if (byte_cnt_r == 4'd15) state_s = WAIT; else state_s = LOAD;
      WAIT: begin
        if (core_valid) begin
          state_s = CAPT;
        end else if (to_cnt_r == TO_LAST) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      CAPT: if (byte_cnt_r == 4'd14) state_s = DONE; else state_s = CAPT;
      DONE: if (bus.out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs; status flags are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      core_rst_r  <= 1'b1;
      keyin_r     <= 8'd0;
      datain_r    <= 8'd0;
      key_sr_r    <= 128'd0;
      data_sr_r   <= 128'd0;
      res_r       <= 128'd0;
      err_r       <= 1'b0;
      byte_cnt_r  <= 4'd0;
      to_cnt_r    <= {TW{1'b0}};
    end else begin
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      out_valid_r <= (state_s == DONE);
      core_rst_r  <= (state_s == IDLE);
      keyin_r     <= 8'd0;
      datain_r    <= 8'd0;
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            // Byte 0 goes straight to the output register; the rest queue up.
            keyin_r    <= bus.in_key[127:120];
            datain_r   <= bus.in_data[127:120];
            key_sr_r   <= {bus.in_key[119:0], 8'd0};
            data_sr_r  <= {bus.in_data[119:0], 8'd0};
            byte_cnt_r <= 4'd0;
            err_r      <= 1'b0;
          end
        end
        LOAD: begin
          to_cnt_r <= {TW{1'b0}};
          if (byte_cnt_r != 4'd15) begin
            byte_cnt_r <= byte_cnt_r + 4'd1;
            keyin_r    <= key_sr_r[127:120];
            datain_r   <= data_sr_r[127:120];
            key_sr_r   <= {key_sr_r[119:0], 8'd0};
            data_sr_r  <= {data_sr_r[119:0], 8'd0};
          end
        end
        WAIT: begin
          byte_cnt_r <= 4'd0;
          to_cnt_r   <= to_cnt_r + TO_ONE;
          if (core_valid) begin
            res_r <= {res_r[119:0], core_dout};
          end else if (to_cnt_r == TO_LAST) begin
            res_r <= 128'd0;
            err_r <= 1'b1;
          end
        end
        CAPT: begin
          byte_cnt_r <= byte_cnt_r + 4'd1;
          res_r      <= {res_r[119:0], core_dout};
        end
        DONE: begin
          res_r <= res_r;
        end
        default: begin
          res_r <= res_r;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = res_r;
  assign bus.out_err   = err_r;
  assign busy          = busy_r;
  assign core_rst      = core_rst_r;
  assign core_keyin    = keyin_r;
  assign core_datain   = datain_r;
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Scoreboard bench for aes_stream_ctrl driving a behavioural byte-serial core model.
module tb_aes_stream_ctrl;
  localparam int           TIMEOUT  = 16;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] SEQ_CT   = 128'h101112131415161718191a1b1c1d1e1f;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, core_rst;
  logic [7:0] core_keyin, core_datain;
  logic [7:0] core_dout  = 8'd0;
  logic       core_valid = 1'b0;

  aes_stream_ctrl_if bus();

  aes_stream_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .core_rst(core_rst),
    .core_keyin(core_keyin), .core_datain(core_datain),
    .core_dout(core_dout), .core_valid(core_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Stand-in cipher: the FIPS-197 vector maps to its published ciphertext, anything else to a lane-sensitive mix.
  function automatic logic [127:0] core_ct(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    else return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;
  endfunction

  // Core model knobs: cycles after load before done, never finish, or emit 0x10..0x1f.
  int core_lat  = 2;
  bit core_dead = 1'b0;
  bit core_seq  = 1'b0;

  int           m_cnt = 0, m_wait = 0, m_idx = 0;
  logic [127:0] m_key = 128'd0, m_pt = 128'd0, m_ct = 128'd0;

  // Core model, updated on the falling edge so the DUT samples settled values.
  always @(negedge clk) begin
    if (core_rst) begin
      m_cnt = 0; m_wait = 0; m_idx = 0;
      core_valid = 1'b0; core_dout = 8'd0;
    end else if (m_cnt < 16) begin
      m_key = {m_key[119:0], core_keyin};
      m_pt  = {m_pt[119:0], core_datain};
      m_cnt++;
    end else if (!core_valid) begin
      if (!core_dead && m_wait == core_lat) begin
        m_ct       = core_seq ? SEQ_CT : core_ct(m_key, m_pt);
        core_valid = 1'b1;
        m_idx      = 0;
        core_dout  = m_ct[127:120];
      end else begin
        m_wait++;
      end
    end else if (m_idx < 15) begin
      m_idx++;
      m_ct      = {m_ct[119:0], 8'd0};
      core_dout = m_ct[127:120];
    end
  end

  typedef struct {
    logic         err;
    logic [127:0] data;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   rise_cyc = 0;
  logic prev_ov = 1'b0;
  bit   overlap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push expectations on accept, compare on result handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.in_ready && busy) overlap = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        check_eq("accept_core_rst", 128'(core_rst), 128'd1);
        mon_e.err  = core_dead;
        mon_e.data = core_dead ? 128'd0 : (core_seq ? SEQ_CT : core_ct(bus.in_key, bus.in_data));
        mon_e.lat  = core_dead ? 17 + TIMEOUT : 17 + core_lat + 16;
        mon_e.acc  = cyc;
        sb.push_back(mon_e);
      end
      if (bus.out_valid && !prev_ov) rise_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_result", 128'(sb.size()), 128'd1);
        end else begin
          mon_e = sb.pop_front();
          check_eq("out_data", bus.out_data, mon_e.data);
          check_eq("out_err", 128'(bus.out_err), 128'(mon_e.err));
          check_eq("latency", 128'(rise_cyc - mon_e.acc), 128'(mon_e.lat));
        end
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic send(input logic [127:0] k, input logic [127:0] p, input bit hold);
    int n = 0;
    bus.in_key   = k;
    bus.in_data  = p;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check_eq("accept_timeout", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 128'(sb.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  logic [127:0] keys [3];
  logic [127:0] pts  [3];
  int           n;

  initial begin
    keys[0] = FIPS_KEY;                                 pts[0] = FIPS_PT;
    keys[1] = 128'hdeadbeef_01234567_89abcdef_fedcba98; pts[1] = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    keys[2] = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c; pts[2] = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_key = 128'd0; bus.in_data = 128'd0; bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check_eq("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check_eq("rst_out_err", 128'(bus.out_err), 128'd0);
    check_eq("rst_out_data", bus.out_data, 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_core_rst", 128'(core_rst), 128'd1);
    check_eq("rst_core_keyin", 128'(core_keyin), 128'd0);
    check_eq("rst_core_datain", 128'(core_datain), 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 vector with the consumer always ready.
    send(FIPS_KEY, FIPS_PT, 1'b0);
    drain(200);

    // Backpressure: hold out_ready low for 10 cycles after out_valid.
    bus.out_ready = 1'b0;
    send(FIPS_KEY, FIPS_PT, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_valid_seen", 128'(bus.out_valid), 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_valid_hold", 128'(bus.out_valid), 128'd1);
      check_eq("bp_data_hold", bus.out_data, FIPS_CT);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("bp_in_ready_after", 128'(bus.in_ready), 128'd1);
    check_eq("bp_busy_after", 128'(busy), 128'd0);
    drain(50);

    // Back-to-back requests with in_valid held high.
    overlap = 1'b0;
    core_lat = 4;
    for (int i = 0; i < 3; i++) send(keys[i], pts[i], i < 2);
    drain(400);
    check_eq("ready_while_busy", 128'(overlap), 128'd0);

    // Stalled core: timeout with error and zero data.
    core_dead = 1'b1;
    send(keys[1], pts[1], 1'b0);
    drain(200);
    core_dead = 1'b0;

    // Reset during LOAD cycle 7 discards the request.
    core_lat = 2;
    send(FIPS_KEY, FIPS_PT, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_busy", 128'(busy), 128'd0);
    check_eq("mid_rst_core_rst", 128'(core_rst), 128'd1);
    check_eq("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    check_eq("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1;
    send(FIPS_KEY, FIPS_PT, 1'b0);
    drain(200);

    // Core done three cycles into WAIT, emitting bytes 0x10..0x1f.
    core_seq = 1'b1;
    core_lat = 3;
    send(keys[2], pts[2], 1'b0);
    drain(200);
    core_seq = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/aes_stream_ctrl.md
# aes_stream_ctrl

Block-level sequencer for the byte-serial AES-128 encryption core. Accepts one 128-bit key and one 128-bit plaintext block over a valid/ready handshake. Resets the core and streams the 16 key and data bytes into it in lockstep. Waits for the core's done flag, collects the 16 ciphertext bytes and returns the 128-bit result over a second valid/ready handshake, with a timeout guard against a stalled core.

## Interface
- TIMEOUT, 1024: maximum WAIT cycles before aborting with error; legal range 2..65535.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request carries a key/plaintext pair
- in_ready  out  1  controller can accept a request
- in_key  in  128  AES key; byte 0 = [127:120]
- in_data  in  128  plaintext; byte 0 = [127:120]
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  128  ciphertext; byte 0 = [127:120]
- out_err  out  1  qualifies out_valid: core timed out, out_data = 0
- busy  out  1  state != IDLE
- core_rst  out  1  reset to AES core, registered
- core_keyin  out  8  key byte to core
- core_datain  out  8  data byte to core
- core_dout  in  8  ciphertext byte from core
- core_valid  in  1  core done flag; sticky high until core reset

## Operation
- States: IDLE, LOAD, WAIT, CAPT, DONE.
- IDLE:
  - in_ready = 1 and core_rst = 1; the core is held in reset while idle.
  - On in_valid: load the key and data shift registers, clear the byte counter, go to LOAD.
- LOAD:
  - core_rst = 0.
  - In LOAD cycle k (k = 0..15), core_keyin and core_datain carry byte k of the key and plaintext.
  - Both shift registers shift left 8 bits per cycle.
  - After 16 cycles, go to WAIT and clear the timeout counter.
- WAIT:
  - core_valid is ignored in IDLE and LOAD.
  - In WAIT, the first cycle core_valid is sampled high: capture core_dout as byte 0, then go to CAPT.
  - If the counter reaches TIMEOUT-1 without core_valid: go to DONE with out_err = 1 and out_data = 0.
- CAPT:
  - Capture core_dout on each of the next 15 cycles as bytes 1..15.
  - Shift-in order: the first captured byte ends in [127:120].
  - core_valid is not rechecked during CAPT.
- DONE:
  - out_valid = 1; out_data and out_err are held stable.
  - On out_ready, go to IDLE.
  - core_rst returns to 1 from the next cycle.
- core_keyin and core_datain are 0 outside LOAD.
- in_valid outside IDLE is ignored; in_ready = 0 there.
- Counters: 4-bit byte counter; timeout counter width = clog2(TIMEOUT). There is no wrap-around; each counter is cleared on every state entry that uses it.
- Reset values: state = IDLE, core_rst = 1, in_ready = 1, out_valid = 0, out_err = 0, out_data = 0, busy = 0, core_keyin = 0, core_datain = 0.
- Reset mid-operation (any state): return to IDLE in the next cycle, discard the partial result, and assert core_rst. No out_valid is produced for the aborted request.

## Timing
- Accept at cycle t, when in_valid and in_ready are both high.
- LOAD occupies cycles t+1..t+16; core_rst is 0 from t+1.
- WAIT starts at t+17.
- If core_valid is first high at cycle w (w ≥ t+17):
  - CAPT covers w+1..w+15;
  - out_valid rises at w+16.
- Timeout: out_valid with out_err rises at t+17+TIMEOUT.
- Handshake: once out_valid is high, it stays high with stable data until out_ready is sampled high.
- Release at cycle r: IDLE at r+1; in_ready = 1 at r+1; the earliest next accept is r+1.
- Minimum IDLE dwell is one cycle, so the core always sees core_rst = 1 for at least one cycle before a load.

## Test plan
- FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, connected to the real core → out_data = 69c4e0d86a7b0430d8cdb78070b4c55a, out_err = 0.
- Backpressure: same vector with out_ready low for 10 cycles after out_valid → out_valid and out_data stable throughout; IDLE and in_ready = 1 the cycle after out_ready is sampled high.
- Back-to-back: three requests with in_valid held high → three correct results in order; each LOAD is preceded by ≥1 cycle of core_rst = 1; no request is accepted while busy.
- Timeout: TIMEOUT = 16, core_valid tied 0 → out_valid at t+33 with out_err = 1 and out_data = 0.
- Reset in LOAD: assert rst at LOAD cycle 7 → next cycle state = IDLE, core_rst = 1, out_valid = 0; a following request still produces the correct vector result.
- Core model with core_valid first high at t+20 and bytes 0x10..0x1f driven in order → out_data = 101112131415161718191a1b1c1d1e1f at t+36.
